// File: rtl/cmd_sched_mem.sv
// cmd_sched_mem: timed-command store with a scanning dispatcher.
// Commands (start time + payload) live in DEPTH slots. A two-stage scanner
// walks the slots, purges commands whose time has passed and hands the
// first command that falls inside the lead window to the sync block.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. Once out_valid rises, it and out_time/out_payload hold
// until out_ready is seen. wr_ready does not depend on wr_valid.
module cmd_sched_mem #(
    parameter int DEPTH = 256,
    parameter int TW    = 64,
    parameter int PW    = 274,
    parameter int LEAD  = 384,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic [TW-1:0] TIME,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [TW-1:0] wr_time,
    input  logic [PW-1:0] wr_payload,
    input  logic          clr_all,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] out_time,
    output logic [PW-1:0] out_payload,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          expired
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   scan_ptr_q, scan_ptr_d;
    logic            e_valid_q, e_valid_d;
    logic [AW-1:0]   e_idx_q, e_idx_d;
    logic            out_valid_q, out_valid_d;
    logic [TW-1:0]   out_time_q, out_time_d;
    logic [PW-1:0]   out_payload_q, out_payload_d;
    logic            ovf_q, ovf_d;
    logic            expired_q, expired_d;

    // Slot storage, RAM style: no reset, one write port, registered read.
    logic [TW-1:0]   mem_time    [DEPTH];
    logic [PW-1:0]   mem_payload [DEPTH];
    logic [TW-1:0]   rd_time_q;
    logic [PW-1:0]   rd_payload_q;

    logic [AW-1:0]   free_idx;
    logic            wr_fire;
    logic            scan_en;
    logic            e_hit;
    logic            e_late;
    logic            e_due;
    logic [TW:0]     lead_end;

    assign wr_ready = (count_q < CW'(DEPTH)) && !clr_all;
    assign wr_fire  = wr_valid && wr_ready;
    // The R stage only advances while scanning; HOLD freezes the whole pipe.
    assign scan_en  = (state_q == SCAN) && !clr_all;
    // Window end kept one bit wider so TIME+LEAD never wraps.
    assign lead_end = {1'b0, TIME} + (TW + 1)'(LEAD);

    // Lowest-index free slot for the next write.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = AW'(i);
        end
    end

    // E-stage decode: the slot must have been valid when read and still be valid.
    always_comb begin
        e_hit  = (state_q == SCAN) && e_valid_q && valid_q[e_idx_q];
        e_late = rd_time_q < TIME;
        e_due  = !e_late && ({1'b0, rd_time_q} < lead_end);
    end

    // Next-state logic for scanner FSM, bitmap, occupancy and output register.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        count_d       = count_q;
        scan_ptr_d    = scan_ptr_q;
        e_valid_d     = e_valid_q;
        e_idx_d       = e_idx_q;
        out_valid_d   = out_valid_q;
        out_time_d    = out_time_q;
        out_payload_d = out_payload_q;
        ovf_d         = wr_valid && !wr_ready && !clr_all;
        expired_d     = 1'b0;

        if (wr_fire) begin
            valid_d[free_idx] = 1'b1;
        end

        case (state_q)
            SCAN: begin
                // R stage: sample the bitmap alongside the array read.
                e_valid_d  = valid_q[scan_ptr_q];
                e_idx_d    = scan_ptr_q;
                scan_ptr_d = scan_ptr_q + AW'(1);
                if (e_hit && e_late) begin
                    valid_d[e_idx_q] = 1'b0;
                    expired_d        = 1'b1;
                end else if (e_hit && e_due) begin
                    valid_d[e_idx_q] = 1'b0;
                    out_valid_d      = 1'b1;
                    out_time_d       = rd_time_q;
                    out_payload_d    = rd_payload_q;
                    state_d          = HOLD;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase

        // One slot freed and one filled in the same cycle cancel out.
        if (wr_fire && !(e_hit && (e_late || e_due))) begin
            count_d = count_q + CW'(1);
        end else if (!wr_fire && e_hit && (e_late || e_due)) begin
            count_d = count_q - CW'(1);
        end

        // Flush wins over everything; the in-flight E sample is squashed.
        if (clr_all) begin
            state_d     = SCAN;
            valid_d     = '0;
            count_d     = '0;
            scan_ptr_d  = '0;
            e_valid_d   = 1'b0;
            out_valid_d = 1'b0;
            expired_d   = 1'b0;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCAN;
            valid_q       <= '0;
            count_q       <= '0;
            scan_ptr_q    <= '0;
            e_valid_q     <= 1'b0;
            e_idx_q       <= '0;
            out_valid_q   <= 1'b0;
            out_time_q    <= '0;
            out_payload_q <= '0;
            ovf_q         <= 1'b0;
            expired_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            count_q       <= count_d;
            scan_ptr_q    <= scan_ptr_d;
            e_valid_q     <= e_valid_d;
            e_idx_q       <= e_idx_d;
            out_valid_q   <= out_valid_d;
            out_time_q    <= out_time_d;
            out_payload_q <= out_payload_d;
            ovf_q         <= ovf_d;
            expired_q     <= expired_d;
        end
    end

    // Array write port: accepted command goes to the chosen free slot.
    always_ff @(posedge CLK) begin
        if (wr_fire) begin
            mem_time[free_idx]    <= wr_time;
            mem_payload[free_idx] <= wr_payload;
        end
    end

    // Array read port: registered read of the slot under the scan pointer.
    always_ff @(posedge CLK) begin
        if (scan_en) begin
            rd_time_q    <= mem_time[scan_ptr_q];
            rd_payload_q <= mem_payload[scan_ptr_q];
        end
    end

    assign out_valid   = out_valid_q;
    assign out_time    = out_time_q;
    assign out_payload = out_payload_q;
    assign count       = count_q;
    assign ovf         = ovf_q;
    assign expired     = expired_q;

endmodule
